scan_mem_loader: RTL and testbench
==================================

// Module: scan_mem_loader
// PURPOSE
//  Upstream stage of the min/max scanner. Accepts a stream of DEPTH data words over valid/ready.
//  Stores the words in an internal DEPTH x DATA_WIDTH RAM.
//  Pulses scan_start for one cycle, then serves the scanner's address/data read port.
//  Holds busy until the scanner reports scan_done.
// PARAMETERS
//  ADDR_WIDTH  10    address width; DEPTH = 2**ADDR_WIDTH
//  DATA_WIDTH  8     width of one stored word
// PORTS
//  clk         in   1           single clock, all logic on posedge
//  rst         in   1           synchronous, active-high reset
//  load_req    in   1           1-cycle request to begin a new load (honoured only in IDLE)
//  in_valid    in   1           upstream word valid
//  in_data     in   DATA_WIDTH  upstream word
//  in_ready    out  1           loader accepts in_data this cycle
//  scan_start  out  1           1-cycle start pulse to scanner
//  rd_addr     in   ADDR_WIDTH  scanner read address
//  rd_data     out  DATA_WIDTH  registered read data, valid 1 cycle after rd_addr
//  scan_done   in   1           scanner finished (level or pulse)
//  busy        out  1           high in LOAD, START, SCAN
//  loaded      out  1           high once a full DEPTH-word load has completed
//  wr_count    out  ADDR_WIDTH  number of words accepted in current load (mod DEPTH)
// BEHAVIOUR
//  Reset: the following clear to 0 on the next posedge with rst=1.
//   - state=IDLE
//   - in_ready, scan_start, busy, loaded, rd_data, wr_count
//   - RAM contents are not cleared.
//  FSM states:
//   - IDLE: busy=0, in_ready=0. load_req=1 -> LOAD, wr_count<=0, loaded<=0.
//   - LOAD: in_ready=1. Handshake = in_valid & in_ready.
//     Each handshake writes RAM[wr_count]<=in_data and increments wr_count.
//     The handshake at wr_count==DEPTH-1 is the last word: wr_count wraps to 0, state -> START.
//     Gaps in in_valid stall the load indefinitely; there is no timeout.
//   - START: scan_start=1 for exactly this one cycle, in_ready=0. Next state is SCAN.
//   - SCAN: wait for scan_done=1, then go to IDLE and set loaded<=1.
//  Read port:
//   - rd_data<=RAM[rd_addr] every cycle regardless of state.
//   - Read-during-write to the same address returns the old data.
//   - rd_addr beyond DEPTH-1 cannot occur; the address is ADDR_WIDTH wide.
//  Ignored inputs:
//   - in_valid outside LOAD: no write, in_ready stays 0.
//   - load_req outside IDLE.
//   - scan_done outside SCAN, including scan_done asserted in START.
//  Simultaneous events:
//   - load_req and scan_done in the same SCAN cycle: go to IDLE only; load_req is dropped.
//   - rst wins over everything.
//  Reset mid-operation:
//   - Mid-LOAD or mid-SCAN -> IDLE with wr_count=0 and loaded=0.
//   - A following load starts again at address 0.
//  Widths:
//   - wr_count is ADDR_WIDTH bits and wraps naturally.
//   - The compare for the last word is wr_count=={ADDR_WIDTH{1'b1}}.
// TESTING
//  1. Full load, no gaps:
//     - Stimulus: load_req, then 1024 words with data=i[7:0], in_valid held high.
//     - Response: in_ready high for 1024 cycles; scan_start is one pulse on the cycle after the last handshake; wr_count=0.
//  2. Readback:
//     - Stimulus: after test 1, rd_addr=5, then rd_addr=1023 on the next cycle.
//     - Response: rd_data=8'h05 one cycle later, then 8'hFF.
//  3. Backpressure gaps:
//     - Stimulus: in_valid toggling 1-0-1 during the load.
//     - Response: only handshake cycles write; scan_start comes after exactly 1024 handshakes.
//  4. Reset mid-load:
//     - Stimulus: rst after 300 words, then a new load of 1024 words with data=8'hA5.
//     - Response: busy=0 and wr_count=0 after rst; all addresses read 8'hA5.
//  5. Early/stray controls:
//     - Stimulus: scan_done during LOAD and START; load_req during SCAN.
//     - Response: no state change. Then scan_done in SCAN -> busy=0, loaded=1 on the next cycle.
//  6. Stray stream:
//     - Stimulus: in_valid=1 with data 8'h3C while in IDLE.
//     - Response: in_ready=0, RAM unchanged, wr_count=0.

Source files
------------

// File: rtl/scan_mem_loader.sv
// scan_mem_loader: front end of the min/max scanner.
// Loads DEPTH words from a valid/ready stream into an internal RAM, pulses
// scan_start once the RAM is full, then serves the scanner's read port and
// stays busy until the scanner reports scan_done.
//
// Handshake: a word transfers on a posedge where in_valid && in_ready are
// both high. in_ready is high only in LOAD. The upstream source may drop
// in_valid at any time. in_ready does not depend on in_valid.
module scan_mem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  scan_start,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  scan_done,
    output logic                  busy,
    output logic                  loaded,
    output logic [ADDR_WIDTH-1:0] wr_count,
    output logic [1:0]            dbg_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_SCAN  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_count_q, wr_count_d;
    logic                  loaded_q, loaded_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  wr_en;
    logic                  last_word;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign last_word = (wr_count_q == {ADDR_WIDTH{1'b1}});

    // Next-state and Moore outputs; every output defaults low.
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        loaded_d   = loaded_q;
        in_ready   = 1'b0;
        scan_start = 1'b0;
        busy       = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d    = S_LOAD;
                    wr_count_d = '0;
                    loaded_d   = 1'b0;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    wr_en      = 1'b1;
                    wr_count_d = wr_count_q + ADDR_WIDTH'(1);
                    if (last_word) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                scan_start = 1'b1;
                busy       = 1'b1;
                state_d    = S_SCAN;
            end
            S_SCAN: begin
                busy = 1'b1;
                // load_req arriving with scan_done is intentionally dropped
                if (scan_done) begin
                    state_d  = S_IDLE;
                    loaded_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers and read data register, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_count_q <= '0;
            loaded_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            loaded_q   <= loaded_d;
            rd_data_q  <= mem[rd_addr];
        end
    end

    // RAM write port; contents survive reset. A read of the address being
    // written in the same cycle sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_count_q] <= in_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign loaded    = loaded_q;
    assign wr_count  = wr_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_scan_mem_loader.sv
// Bench for scan_mem_loader: randomized stream loads checked against a
// word-array model of the RAM plus the expected protocol sequence.
module tb_scan_mem_loader;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          load_req;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          scan_start;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          scan_done;
    logic          busy;
    logic          loaded;
    logic [AW-1:0] wr_count;
    logic [1:0]    dbg_state;

    scan_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_req  (load_req),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .scan_start(scan_start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .scan_done (scan_done),
        .busy      (busy),
        .loaded    (loaded),
        .wr_count  (wr_count),
        .dbg_state (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference RAM image
    logic [DW-1:0] ref_mem   [DEPTH];
    logic          ref_known [DEPTH];
    logic          exp_loaded;

    int total;
    int bad;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_in_ready", 32'(in_ready), 0);
        check_eq("rst_scan_start", 32'(scan_start), 0);
        check_eq("rst_loaded", 32'(loaded), 0);
        check_eq("rst_wr_count", 32'(wr_count), 0);
        check_eq("rst_rd_data", 32'(rd_data), 0);
        rst = 1'b0;
        exp_loaded = 1'b0;
    endtask

    // mode 0: data = index, no gaps; mode 1: random data with random gaps;
    // mode 2: constant 8'hA5, no gaps. Stops after n_words handshakes.
    task automatic run_load(input int n_words, input int mode);
        int            hs;
        int            cyc;
        logic          pend;
        logic [DW-1:0] pend_exp;
        logic [AW-1:0] a;
        logic [AW-1:0] idx;
        logic          v;
        logic [DW-1:0] d;
        hs   = 0;
        cyc  = 0;
        pend = 1'b0;
        pend_exp = '0;
        @(negedge clk);
        load_req = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        load_req = 1'b0;
        exp_loaded = 1'b0;
        check_eq("load_busy", 32'(busy), 1);
        check_eq("load_wr_count0", 32'(wr_count), 0);
        check_eq("load_loaded", 32'(loaded), 0);
        while (hs < n_words && cyc < 8000) begin
            if (pend) check_eq("rd_during_wr", 32'(rd_data), 32'(pend_exp));
            idx = AW'(hs);
            check_eq("in_ready_load", 32'(in_ready), 1);
            check_eq("wr_count_load", 32'(wr_count), 32'(idx));
            check_eq("no_start_in_load", 32'(scan_start), 0);
            v = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (mode == 0)      d = idx[DW-1:0];
            else if (mode == 1) d = DW'($urandom);
            else                d = 8'hA5;
            scan_done = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 1) == 0) ? idx : AW'($urandom);
            rd_addr  = a;
            pend     = ref_known[a];
            pend_exp = ref_mem[a];
            in_valid = v;
            in_data  = d;
            if (v) begin
                ref_mem[idx]   = d;
                ref_known[idx] = 1'b1;
                hs++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        scan_done = 1'b0;
        if (pend) check_eq("rd_during_wr", 32'(rd_data), 32'(pend_exp));
        if (cyc >= 8000) check_eq("load_timeout", 32'(hs), 32'(n_words));
    endtask

    // Called at the negedge right after the last handshake edge.
    task automatic start_and_scan(input logic simul_req);
        check_eq("start_pulse", 32'(scan_start), 1);
        check_eq("start_in_ready", 32'(in_ready), 0);
        check_eq("start_busy", 32'(busy), 1);
        check_eq("start_wr_count", 32'(wr_count), 0);
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        scan_done = 1'b1;   // ignored while in START
        @(negedge clk);
        check_eq("scan_pulse_gone", 32'(scan_start), 0);
        check_eq("scan_busy", 32'(busy), 1);
        check_eq("scan_in_ready", 32'(in_ready), 0);
        scan_done = 1'b0;
        load_req  = 1'b1;   // ignored while in SCAN
        @(negedge clk);
        check_eq("scan_busy_req", 32'(busy), 1);
        check_eq("scan_loaded_early", 32'(loaded), 0);
        check_eq("scan_no_restart", 32'(scan_start), 0);
        load_req  = simul_req;
        scan_done = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        exp_loaded = 1'b1;
        check_eq("done_busy", 32'(busy), 0);
        check_eq("done_loaded", 32'(loaded), 32'(exp_loaded));
        load_req  = 1'b0;
        scan_done = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_in_ready", 32'(in_ready), 0);
    endtask

    // Pipelined readback of every address, sequential or random order.
    task automatic read_sweep(input logic rand_order);
        logic [AW-1:0] prev;
        logic [AW-1:0] nxt;
        @(negedge clk);
        prev    = '0;
        rd_addr = prev;
        for (int k = 1; k <= DEPTH; k++) begin
            nxt = rand_order ? AW'($urandom) : AW'(k);
            @(negedge clk);
            if (ref_known[prev]) check_eq("readback", 32'(rd_data), 32'(ref_mem[prev]));
            rd_addr = nxt;
            prev    = nxt;
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        load_req  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        rd_addr   = '0;
        scan_done = 1'b0;
        exp_loaded = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        do_reset();

        // full load, data = index
        run_load(DEPTH, 0);
        start_and_scan(1'b1);

        // readback of two points, then everything
        @(negedge clk);
        rd_addr = 10'd5;
        @(negedge clk);
        check_eq("read_5", 32'(rd_data), 32'h05);
        rd_addr = 10'd1023;
        @(negedge clk);
        check_eq("read_1023", 32'(rd_data), 32'hFF);
        read_sweep(1'b0);

        // stray stream in IDLE must not write
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h3C;
            if (k > 0) begin
                check_eq("stray_in_ready", 32'(in_ready), 0);
                check_eq("stray_wr_count", 32'(wr_count), 0);
                check_eq("stray_busy", 32'(busy), 0);
                check_eq("stray_loaded", 32'(loaded), 32'(exp_loaded));
            end
        end
        in_valid = 1'b0;
        read_sweep(1'b1);

        // random data with backpressure gaps
        run_load(DEPTH, 1);
        start_and_scan(1'b0);
        read_sweep(1'b1);

        // reset mid-load, then a fresh constant load
        run_load(300, 1);
        check_eq("midload_busy", 32'(busy), 1);
        do_reset();
        check_eq("after_rst_state_idle_ready", 32'(in_ready), 0);
        run_load(DEPTH, 2);
        start_and_scan(1'b1);
        read_sweep(1'b0);

        // reset mid-scan clears loaded
        run_load(DEPTH, 1);
        check_eq("pre_scan_start", 32'(scan_start), 1);
        @(negedge clk);
        check_eq("in_scan_busy", 32'(busy), 1);
        do_reset();
        read_sweep(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard time limit
    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
